spi_miso_router: RTL and testbench
==================================

// Module: spi_miso_router
// PURPOSE
//  Parametrised, registered successor of the combinational MISO decoder. Routes one of N
//  SPI slave MISO lines to the master, chosen by a CODE_W select code. The code is latched
//  only at the start of a frame (cs_n falling), so selection never changes mid-frame.
//  Adds input synchronisation, invalid-code, code-change and frame-timeout detection.
//  Sits between the board SPI slaves and the master-side SPI core, in the system clock domain.
// PARAMETERS
//  N_SLAVES     4                                      number of MISO inputs (1..16)
//  CODE_W       4                                      select-code width
//  CODE_TABLE   {4'b0111,4'b1011,4'b1101,4'b0011}      packed codes; slice i selects miso_in[i]
//  IDLE_VALUE   1'b1                                   miso_out level when nothing is selected
//  SYNC_STAGES  2                                      synchroniser depth for miso_in/cs_n (>=2)
//  TIMEOUT_CYC  65535                                  max clk cycles per frame; 0 disables
// PORTS
//  clk          in   1            system clock
//  rst          in   1            asynchronous, active-high reset
//  code         in   CODE_W       slave select code, clk domain
//  cs_n         in   1            master chip select, active low, asynchronous to clk
//  miso_in      in   N_SLAVES     slave MISO lines, asynchronous to clk
//  err_clr      in   1            single-cycle pulse, clears all sticky error flags
//  miso_out     out  1            routed MISO, registered
//  busy         out  1            1 while state is ACTIVE or FAULT
//  sel_valid    out  1            1 while ACTIVE with a code found in CODE_TABLE
//  sel_idx      out  $clog2(N_SLAVES) (min 1)  index latched at frame start
//  err_inv      out  1            sticky: frame started with a code not in CODE_TABLE
//  err_chg      out  1            sticky: code changed while ACTIVE
//  err_to       out  1            sticky: frame exceeded TIMEOUT_CYC
// BEHAVIOUR
//  Reset values: miso_out=IDLE_VALUE, busy=0, sel_valid=0, sel_idx=0, all err_*=0,
//   sync chains=1, timeout counter=0, state=WAIT.
//  cs_n and miso_in pass through SYNC_STAGES flops; cs_s = synced cs_n. code is sampled raw.
//  FSM:
//   WAIT   : after reset; go IDLE when cs_s==1 (never join a frame already in progress).
//   IDLE   : on cs_s 1->0 latch code; lookup lowest matching slice i -> sel_idx=i,
//            sel_valid=1; no match -> sel_valid=0, set err_inv; go ACTIVE; counter=0.
//   ACTIVE : counter +1 per cycle; cs_s==1 -> IDLE; counter==TIMEOUT_CYC-1 (TIMEOUT_CYC!=0)
//            -> FAULT, set err_to; code != latched code -> set err_chg (selection unchanged).
//   FAULT  : miso_out forced IDLE_VALUE, sel_valid=0; cs_s==1 -> IDLE.
//  cs_s rise and timeout in the same cycle: rise wins (go IDLE, err_to not set).
//  miso_out: ACTIVE & sel_valid -> synced miso_in[sel_idx], else IDLE_VALUE; registered.
//  Latency: miso_in pin to miso_out = SYNC_STAGES+1 clk; cs_n fall to busy = SYNC_STAGES+1 clk.
//  Duplicate codes in CODE_TABLE: lowest index wins. Counter width = $clog2(TIMEOUT_CYC+1),
//   saturating, never wraps.
//  Sticky errors: set has priority over err_clr in the same cycle; err_clr otherwise clears.
//  Reset asserted mid-frame: outputs return to reset values at once; back to WAIT, so no
//   traffic is routed until cs_n has been seen high.
// TESTING
//  1. Reset, cs_n=1, code=4'b1101, cs_n->0, miso_in[1] toggles -> busy after 3 clk,
//     sel_idx=1, miso_out follows miso_in[1] with 3-clk lag; other lines ignored.
//  2. code=4'b0000 at cs_n fall -> err_inv=1, sel_valid=0, miso_out stays 1 whole frame.
//  3. Mid-frame code 0011->0111 -> err_chg=1, sel_idx stays 0; next frame selects index 3.
//  4. TIMEOUT_CYC=16, hold cs_n low 40 clk -> FAULT at 16th ACTIVE cycle, err_to=1,
//     miso_out=1; cs_n high -> IDLE; err_clr pulse -> err_to=0.
//  5. rst pulsed with cs_n low mid-frame -> busy=0, miso_out=1; stays idle until cs_n goes
//     high then low; that next frame routes normally.
//  6. err_clr in same cycle as a new invalid-code frame start -> err_inv remains 1.

Source files
------------

// File: rtl/spi_miso_router.sv
// Registered SPI MISO router: latches a slave-select code at frame start and routes the matching
// slave's synchronised MISO line to the master, flagging invalid codes, mid-frame code changes and frame timeouts.
module spi_miso_router #(
    parameter int                           N_SLAVES    = 4,
    parameter int                           CODE_W      = 4,
    parameter logic [N_SLAVES*CODE_W-1:0]   CODE_TABLE  = {4'b0111, 4'b1011, 4'b1101, 4'b0011},
    parameter logic                         IDLE_VALUE  = 1'b1,
    parameter int                           SYNC_STAGES = 2,
    parameter int                           TIMEOUT_CYC = 65535,
    localparam int                          IDX_W       = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   code,
    input  logic                cs_n,
    input  logic [N_SLAVES-1:0] miso_in,
    input  logic                err_clr,
    output logic                miso_out,
    output logic                busy,
    output logic                sel_valid,
    output logic [IDX_W-1:0]    sel_idx,
    output logic                err_inv,
    output logic                err_chg,
    output logic                err_to
);

    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int WCNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [WCNT_W-1:0] FLUSHED = WCNT_W'(SYNC_STAGES);

    typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_ACTIVE, ST_FAULT} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
    logic [CODE_W-1:0]   code_lat, code_nxt;
    logic                hit_lat, hit_nxt;
    logic [IDX_W-1:0]    idx_lat, idx_nxt;
    logic                set_inv, set_chg, set_to;
    logic                lut_hit;
    logic [IDX_W-1:0]    lut_idx;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [N_SLAVES-1:0]    miso_sync [SYNC_STAGES];
    logic                   cs_s;
    logic [N_SLAVES-1:0]    miso_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                miso_sync[i] <= '1;
            end
        end else begin
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            miso_sync[0] <= miso_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                miso_sync[i] <= miso_sync[i-1];
            end
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign miso_s = miso_sync[SYNC_STAGES-1];

    // Scan from the top so the lowest matching slice is the one left standing.
    always_comb begin
        lut_hit = 1'b0;
        lut_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (code == CODE_TABLE[i*CODE_W +: CODE_W]) begin
                lut_hit = 1'b1;
                lut_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wcnt_nxt  = wcnt;
        code_nxt  = code_lat;
        hit_nxt   = hit_lat;
        idx_nxt   = idx_lat;
        set_inv   = 1'b0;
        set_chg   = 1'b0;
        set_to    = 1'b0;
        case (state)
            // The synchroniser still holds reset ones for SYNC_STAGES cycles, so cs_s is
            // only trusted once it carries real pin samples; otherwise a frame already in
            // progress at reset release would be joined.
            ST_WAIT: begin
                if (wcnt != FLUSHED) begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end else if (cs_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!cs_s) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                    code_nxt  = code;
                    hit_nxt   = lut_hit;
                    idx_nxt   = lut_idx;
                    set_inv   = !lut_hit;
                end
            end
            ST_ACTIVE: begin
                set_chg = (code != code_lat);
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                if (cs_s) begin
                    state_nxt = ST_IDLE;
                end else if ((TIMEOUT_CYC != 0) && (cnt == TO_LAST)) begin
                    state_nxt = ST_FAULT;
                    set_to    = 1'b1;
                end
            end
            ST_FAULT: begin
                if (cs_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_WAIT;
            cnt      <= '0;
            wcnt     <= '0;
            code_lat <= '0;
            hit_lat  <= 1'b0;
            idx_lat  <= '0;
            err_inv  <= 1'b0;
            err_chg  <= 1'b0;
            err_to   <= 1'b0;
            miso_out <= IDLE_VALUE;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wcnt     <= wcnt_nxt;
            code_lat <= code_nxt;
            hit_lat  <= hit_nxt;
            idx_lat  <= idx_nxt;
            err_inv  <= set_inv | (err_inv & ~err_clr);
            err_chg  <= set_chg | (err_chg & ~err_clr);
            err_to   <= set_to  | (err_to  & ~err_clr);
            // Driven from the next state so the line goes quiet on the same edge as FAULT.
            miso_out <= ((state_nxt == ST_ACTIVE) && hit_nxt) ? miso_s[idx_nxt] : IDLE_VALUE;
        end
    end

    assign busy      = (state == ST_ACTIVE) || (state == ST_FAULT);
    assign sel_valid = (state == ST_ACTIVE) && hit_lat;
    assign sel_idx   = idx_lat;

endmodule

// File: tb/tb_spi_miso_router.sv
// Bench for spi_miso_router: directed table, hand sequences for the corner cases and a
// randomized frame stream checked against a frame-level reference model.
module tb_spi_miso_router;

    localparam int S = 2;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] code;
    logic       cs_n;
    logic [3:0] miso_in;
    logic       err_clr;
    logic       miso_out, busy, sel_valid, err_inv, err_chg, err_to;
    logic [1:0] sel_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_miso_router #(
        .N_SLAVES(4), .CODE_W(4), .CODE_TABLE({4'b0111, 4'b1011, 4'b1101, 4'b0011}),
        .IDLE_VALUE(1'b1), .SYNC_STAGES(S), .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk), .rst(rst), .code(code), .cs_n(cs_n), .miso_in(miso_in), .err_clr(err_clr),
        .miso_out(miso_out), .busy(busy), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .err_inv(err_inv), .err_chg(err_chg), .err_to(err_to)
    );

    // Reference model: pin history queues plus frame-level bookkeeping.
    logic [3:0] tbl [4] = '{4'b0011, 4'b1101, 4'b1011, 4'b0111};
    logic       cs_q [$];
    logic [3:0] mi_q [$];
    bit         m_armed, m_in_frame, m_fault, m_hit;
    int         m_cycles, m_idx;
    logic [3:0] m_code;
    bit         e_inv, e_chg, e_to;
    logic       e_miso;

    function automatic void model_reset();
        cs_q = {};
        mi_q = {};
        for (int i = 0; i < S; i++) begin
            cs_q.push_front(1'bx);
            mi_q.push_front(4'bxxxx);
        end
        m_armed = 0; m_in_frame = 0; m_fault = 0; m_hit = 0;
        m_cycles = 0; m_idx = 0; m_code = '0;
        e_inv = 0; e_chg = 0; e_to = 0; e_miso = 1'b1;
    endfunction

    function automatic void model_edge();
        logic       cs_s;
        logic [3:0] mi_s;
        bit         active, s_inv, s_chg, s_to;
        cs_s = cs_q[S-1];
        mi_s = mi_q[S-1];
        cs_q.push_front(cs_n);
        void'(cs_q.pop_back());
        mi_q.push_front(miso_in);
        void'(mi_q.pop_back());
        active = m_in_frame && !m_fault;
        s_inv = 0; s_chg = 0; s_to = 0;
        if (active && code != m_code) s_chg = 1;
        if (!m_armed) begin
            if (cs_s === 1'b1) m_armed = 1;
        end else if (!m_in_frame) begin
            if (cs_s == 1'b0) begin
                m_in_frame = 1; m_fault = 0; m_cycles = 0; m_code = code;
                m_hit = 0; m_idx = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!m_hit && tbl[i] == code) begin
                        m_hit = 1;
                        m_idx = i;
                    end
                end
                s_inv = !m_hit;
            end
        end else if (cs_s) begin
            m_in_frame = 0;
        end else if (!m_fault) begin
            m_cycles++;
            if (m_cycles == T) begin
                m_fault = 1;
                s_to = 1;
            end
        end
        e_inv = s_inv || (e_inv && !err_clr);
        e_chg = s_chg || (e_chg && !err_clr);
        e_to  = s_to  || (e_to  && !err_clr);
        e_miso = (m_in_frame && !m_fault && m_hit) ? mi_s[m_idx] : 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy",      8'(busy),      8'(m_in_frame));
        chk("sel_valid", 8'(sel_valid), 8'(m_in_frame && !m_fault && m_hit));
        chk("sel_idx",   8'(sel_idx),   8'(m_idx));
        chk("miso_out",  8'(miso_out),  8'(e_miso));
        chk("err_inv",   8'(err_inv),   8'(e_inv));
        chk("err_chg",   8'(err_chg),   8'(e_chg));
        chk("err_to",    8'(err_to),    8'(e_to));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_ticks(input int n);
        cs_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            miso_in = 4'($urandom);
            tick();
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic       cs;
        logic       m1;
        logic       busy;
        logic       mo;
        logic       sv;
        logic [1:0] idx;
    } vec_t;
    vec_t t1 [12];

    initial begin
        t1[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        t1[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        t1[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        t1[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
        t1[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
        t1[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};
        t1[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        t1[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        t1[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};
        t1[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
        t1[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        t1[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};

        rst = 1'b1; cs_n = 1'b1; code = 4'b1101; miso_in = 4'hF; err_clr = 1'b0;
        model_reset();
        #2;
        chk("rst_busy",     8'(busy),      8'd0);
        chk("rst_miso_out", 8'(miso_out),  8'd1);
        chk("rst_sel",      8'(sel_valid), 8'd0);
        chk("rst_idx",      8'(sel_idx),   8'd0);
        chk("rst_errs",     8'({err_inv, err_chg, err_to}), 8'd0);
        #10 rst = 1'b0;

        // Frame selecting slave 1; the other lines carry the inverse pattern.
        for (int i = 0; i < 12; i++) begin
            cs_n    = t1[i].cs;
            miso_in = t1[i].m1 ? 4'b0010 : 4'b1101;
            tick();
            chk($sformatf("t1_busy[%0d]", i), 8'(busy),      8'(t1[i].busy));
            chk($sformatf("t1_mo[%0d]", i),   8'(miso_out),  8'(t1[i].mo));
            chk($sformatf("t1_sv[%0d]", i),   8'(sel_valid), 8'(t1[i].sv));
            chk($sformatf("t1_idx[%0d]", i),  8'(sel_idx),   8'(t1[i].idx));
        end
        idle_ticks(2);

        // Invalid code: nothing routed for the whole frame.
        code = 4'b0000;
        cs_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            miso_in = 4'($urandom);
            tick();
            chk("inv_miso_out", 8'(miso_out), 8'd1);
        end
        chk("inv_err_inv", 8'(err_inv),   8'd1);
        chk("inv_sel",     8'(sel_valid), 8'd0);
        chk("inv_busy",    8'(busy),      8'd1);
        idle_ticks(3);

        // err_clr on the very edge a new invalid frame starts: set must win.
        code = 4'b1111;
        cs_n = 1'b0;
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_vs_set_busy", 8'(busy),    8'd1);
        chk("clr_vs_set_inv",  8'(err_inv), 8'd1);
        idle_ticks(3);
        pulse_clr();
        chk("clr_inv", 8'(err_inv), 8'd0);

        // Mid-frame code change keeps the latched selection.
        code = 4'b0011;
        cs_n = 1'b0;
        repeat (5) tick();
        chk("chg_idx0", 8'(sel_idx),   8'd0);
        chk("chg_sv",   8'(sel_valid), 8'd1);
        code = 4'b0111;
        repeat (2) tick();
        chk("chg_err",  8'(err_chg), 8'd1);
        chk("chg_idx1", 8'(sel_idx), 8'd0);
        idle_ticks(3);
        cs_n = 1'b0;
        repeat (3) tick();
        chk("chg_next_idx",  8'(sel_idx), 8'd3);
        chk("chg_next_busy", 8'(busy),    8'd1);
        idle_ticks(3);
        pulse_clr();

        // Timeout: 16 ACTIVE cycles then FAULT until cs_n returns high.
        code = 4'b1101;
        cs_n = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            miso_in = 4'($urandom);
            tick();
            if (i == 18) begin
                chk("to_pre_err", 8'(err_to),    8'd0);
                chk("to_pre_sv",  8'(sel_valid), 8'd1);
            end
            if (i == 19) begin
                chk("to_err",  8'(err_to),    8'd1);
                chk("to_sv",   8'(sel_valid), 8'd0);
                chk("to_busy", 8'(busy),      8'd1);
            end
            if (i >= 19) chk("to_miso_out", 8'(miso_out), 8'd1);
        end
        idle_ticks(3);
        chk("to_idle_busy", 8'(busy),   8'd0);
        chk("to_sticky",    8'(err_to), 8'd1);
        pulse_clr();
        chk("to_clr", 8'(err_to), 8'd0);

        // Reset in the middle of a frame, cs_n still low afterwards.
        cs_n = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("mrst_busy",     8'(busy),     8'd0);
        chk("mrst_miso_out", 8'(miso_out), 8'd1);
        model_reset();
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            miso_in = 4'($urandom);
            tick();
            chk("mrst_stay_idle", 8'(busy), 8'd0);
        end
        idle_ticks(3);
        cs_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            miso_in = 4'($urandom);
            tick();
        end
        chk("mrst_next_busy", 8'(busy),    8'd1);
        chk("mrst_next_idx",  8'(sel_idx), 8'd1);
        idle_ticks(3);

        // Random frame stream.
        for (int f = 0; f < 60; f++) begin
            int hi, len, chg_at;
            hi = $urandom_range(1, 4);
            for (int c = 0; c < hi; c++) begin
                cs_n = 1'b1;
                miso_in = 4'($urandom);
                err_clr = ($urandom_range(0, 9) == 0);
                tick();
            end
            if ($urandom_range(0, 9) < 7) code = tbl[$urandom_range(0, 3)];
            else code = 4'($urandom);
            len = $urandom_range(1, 24);
            chg_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int c = 0; c < len; c++) begin
                cs_n = 1'b0;
                if (c == chg_at) code = 4'($urandom);
                miso_in = 4'($urandom);
                err_clr = ($urandom_range(0, 9) == 0);
                tick();
            end
            err_clr = 1'b0;
        end
        idle_ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
